// File: rtl/vga_ctrl.sv
// rtl/vga_ctrl.sv - 640x480@60 VGA timing generator with one-cycle-ahead pixel request
module vga_ctrl #(
  parameter int   H_SYNC   = 96,
  parameter int   H_BACK   = 48,
  parameter int   H_VALID  = 640,
  parameter int   H_FRONT  = 16,
  parameter int   V_SYNC   = 2,
  parameter int   V_BACK   = 33,
  parameter int   V_VALID  = 480,
  parameter int   V_FRONT  = 10,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic        locked,
  input  logic [15:0] pix_data,
  output logic        pix_data_req,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic        rgb_valid,
  output logic [15:0] rgb,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam int H_ACT   = H_SYNC + H_BACK;
  localparam int V_ACT   = V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_E  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_E  = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_LO  = 10'(H_ACT);
  localparam logic [9:0] H_ACT_HI  = 10'(H_ACT + H_VALID);
  localparam logic [9:0] H_REQ_LO  = 10'(H_ACT - 1);
  localparam logic [9:0] H_REQ_HI  = 10'(H_ACT + H_VALID - 1);
  localparam logic [9:0] V_ACT_LO  = 10'(V_ACT);
  localparam logic [9:0] V_ACT_HI  = 10'(V_ACT + V_VALID);
  localparam logic [9:0] NO_COORD  = 10'h3FF;

  logic [9:0] cnt_h_q, cnt_h_d;
  logic [9:0] cnt_v_q, cnt_v_d;
  logic       h_last;
  logic       v_win;

  assign h_last = (cnt_h_q == H_LAST);

  // Next-state counters: horizontal always advances, vertical steps at end of line
  always_comb begin
    cnt_h_d = h_last ? 10'd0 : cnt_h_q + 10'd1;
    cnt_v_d = cnt_v_q;
    if (h_last) begin
      cnt_v_d = (cnt_v_q == V_LAST) ? 10'd0 : cnt_v_q + 10'd1;
    end
  end

  // Counter registers; loss of PLL lock restarts the frame just like reset
  always_ff @(posedge vga_clk) begin
    if (sys_rst || !locked) begin
      cnt_h_q <= 10'd0;
      cnt_v_q <= 10'd0;
    end else begin
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
    end
  end

  // Output decodes: request leads the active window by one clock so the
  // source's registered answer lines up with rgb_valid
  always_comb begin
    v_win        = (cnt_v_q >= V_ACT_LO) && (cnt_v_q < V_ACT_HI);
    hsync        = (cnt_h_q < H_SYNC_E) ? SYNC_POL : ~SYNC_POL;
    vsync        = (cnt_v_q < V_SYNC_E) ? SYNC_POL : ~SYNC_POL;
    rgb_valid    = v_win && (cnt_h_q >= H_ACT_LO) && (cnt_h_q < H_ACT_HI);
    pix_data_req = v_win && (cnt_h_q >= H_REQ_LO) && (cnt_h_q < H_REQ_HI);
    pix_x        = pix_data_req ? (cnt_h_q - H_REQ_LO) : NO_COORD;
    pix_y        = pix_data_req ? (cnt_v_q - V_ACT_LO) : NO_COORD;
    rgb          = rgb_valid ? pix_data : 16'h0000;
    frame_start  = (cnt_h_q == 10'd0) && (cnt_v_q == 10'd0);
  end

endmodule

// File: tb/tb_vga_ctrl.sv
// tb/tb_vga_ctrl.sv - directed self-checking bench for vga_ctrl
module tb_vga_ctrl;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        rst, locked, rst_s, locked_s;
  logic [15:0] pix_data;

  logic        req, hsync, vsync, rgb_valid, frame_start;
  logic [9:0]  pix_x, pix_y;
  logic [15:0] rgb;

  logic        req_s, hsync_s, vsync_s, rgb_valid_s, frame_start_s;
  logic [9:0]  pix_x_s, pix_y_s;
  logic [15:0] rgb_s;

  int errors = 0;
  int checks = 0;

  vga_ctrl dut (
    .vga_clk(clk), .sys_rst(rst), .locked(locked), .pix_data(pix_data),
    .pix_data_req(req), .pix_x(pix_x), .pix_y(pix_y), .hsync(hsync), .vsync(vsync),
    .rgb_valid(rgb_valid), .rgb(rgb), .frame_start(frame_start)
  );

  // Small timing: H 4/3/8/2 (17 clocks), V 2/2/4/1 (9 lines), inverted sync
  vga_ctrl #(
    .H_SYNC(4), .H_BACK(3), .H_VALID(8), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(2), .V_VALID(4), .V_FRONT(1),
    .SYNC_POL(1'b0)
  ) dut_s (
    .vga_clk(clk), .sys_rst(rst_s), .locked(locked_s), .pix_data(pix_data),
    .pix_data_req(req_s), .pix_x(pix_x_s), .pix_y(pix_y_s), .hsync(hsync_s), .vsync(vsync_s),
    .rgb_valid(rgb_valid_s), .rgb(rgb_s), .frame_start(frame_start_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int h, v, b;
    int hs_bad, vs_bad, rgb_bad, req_bad, vcnt, rcnt;
    int fs_cnt, last_fs, max_y, y3_line, vcnt_s, s_bad;
    int n;

    rst = 1'b1; locked = 1'b1; rst_s = 1'b1; locked_s = 1'b0;
    pix_data = 16'hF800;
    step(); step(); step();

    chk("rst_hsync", hsync, 1'b1);
    chk("rst_vsync", vsync, 1'b1);
    chk("rst_frame_start", frame_start, 1'b1);
    chk("rst_rgb_valid", rgb_valid, 1'b0);
    chk("rst_req", req, 1'b0);
    chk("rst_pix_x", pix_x, 10'h3FF);
    chk("rst_pix_y", pix_y, 10'h3FF);
    chk("rst_rgb", rgb, 16'h0000);
    chk("rst_s_hsync", hsync_s, 1'b0);
    chk("rst_s_vsync", vsync_s, 1'b0);
    chk("rst_s_frame_start", frame_start_s, 1'b1);

    // Default timing: run the first 36 lines (through the first active line)
    rst = 1'b0;
    hs_bad = 0; vs_bad = 0; rgb_bad = 0; req_bad = 0; vcnt = 0; rcnt = 0;
    b = 35 * 800;
    for (int k = 0; k < 36 * 800; k++) begin
      h = k % 800;
      v = k / 800;
      if (hsync !== (h < 96)) hs_bad++;
      if (vsync !== (v < 2)) vs_bad++;
      if (rgb_valid !== (v == 35 && h >= 144 && h < 784)) rgb_bad++;
      if (rgb_valid) begin
        vcnt++;
        if (rgb !== pix_data) rgb_bad++;
      end else if (rgb !== 16'h0000) rgb_bad++;
      if (req !== (v == 35 && h >= 143 && h < 783)) req_bad++;
      if (req) begin
        rcnt++;
        if (pix_x !== 10'(h - 143) || pix_y !== 10'(v - 35)) req_bad++;
      end else if (pix_x !== 10'h3FF || pix_y !== 10'h3FF) req_bad++;

      if (k == 95)  chk("hsync_c95", hsync, 1'b1);
      if (k == 96)  chk("hsync_c96", hsync, 1'b0);
      if (k == 800) chk("hsync_c800", hsync, 1'b1);
      if (k == 800) chk("frame_start_c800", frame_start, 1'b0);
      if (k == 1599) chk("vsync_c1599", vsync, 1'b1);
      if (k == 1600) chk("vsync_c1600", vsync, 1'b0);
      if (k == b - 800 + 143) chk("req_line34", req, 1'b0);
      if (k == b + 142) chk("req_h142", req, 1'b0);
      if (k == b + 143) begin
        chk("req_h143", req, 1'b1);
        chk("pix_x_h143", pix_x, 10'd0);
        chk("pix_y_h143", pix_y, 10'd0);
        chk("valid_h143", rgb_valid, 1'b0);
        chk("rgb_h143", rgb, 16'h0000);
      end
      if (k == b + 144) begin
        chk("valid_h144", rgb_valid, 1'b1);
        chk("rgb_h144", rgb, 16'hF800);
      end
      if (k == b + 300) begin
        pix_data = 16'h07E0;
        #1;
        chk("rgb_passthru", rgb, 16'h07E0);
        pix_data = 16'hF800;
        #1;
      end
      if (k == b + 782) begin
        chk("req_h782", req, 1'b1);
        chk("pix_x_h782", pix_x, 10'd639);
      end
      if (k == b + 783) begin
        chk("req_h783", req, 1'b0);
        chk("pix_x_h783", pix_x, 10'h3FF);
        chk("valid_h783", rgb_valid, 1'b1);
      end
      if (k == b + 784) begin
        chk("valid_h784", rgb_valid, 1'b0);
        chk("rgb_h784", rgb, 16'h0000);
      end
      step();
    end
    chk("hsync_pattern", hs_bad, 0);
    chk("vsync_pattern", vs_bad, 0);
    chk("rgb_pattern", rgb_bad, 0);
    chk("req_pattern", req_bad, 0);
    chk("valid_per_line", vcnt, 640);
    chk("req_per_line", rcnt, 640);

    // Small timing: free run just over two frames (153 clocks each)
    rst_s = 1'b0; locked_s = 1'b1;
    fs_cnt = 0; last_fs = -1; max_y = 0; y3_line = -1; vcnt_s = 0; s_bad = 0;
    for (int k = 0; k < 331; k++) begin
      h = k % 17;
      v = (k / 17) % 9;
      if (hsync_s !== !(h < 4)) s_bad++;
      if (vsync_s !== !(v < 2)) s_bad++;
      if (frame_start_s !== (h == 0 && v == 0)) s_bad++;
      if (rgb_valid_s !== (h >= 7 && h < 15 && v >= 4 && v < 8)) s_bad++;
      if (req_s !== (h >= 6 && h < 14 && v >= 4 && v < 8)) s_bad++;
      if (rgb_valid_s && k < 153) vcnt_s++;
      if (req_s) begin
        if (int'(pix_y_s) > max_y) max_y = int'(pix_y_s);
        if (pix_y_s == 10'd3 && y3_line < 0) y3_line = v;
      end
      if (frame_start_s) begin
        if (last_fs >= 0) chk("frame_period", k - last_fs, 153);
        last_fs = k;
        fs_cnt++;
      end
      if (k == 152) chk("fs_before_wrap", frame_start_s, 1'b0);
      step();
    end
    chk("small_pattern", s_bad, 0);
    chk("frame_start_count", fs_cnt, 3);
    chk("valid_per_frame", vcnt_s, 32);
    chk("pix_y_max", max_y, 3);
    chk("pix_y_last_line", y3_line, 7);

    // Advance to cnt_h=10, cnt_v=5 of the third frame, then drop lock for 3 clocks
    n = 331;
    while (n < 306 + 5 * 17 + 10) begin
      step();
      n++;
    end
    chk("pre_drop_hsync", hsync_s, 1'b1);
    chk("pre_drop_valid", rgb_valid_s, 1'b1);
    locked_s = 1'b0;
    step();
    chk("drop1_frame_start", frame_start_s, 1'b1);
    chk("drop1_hsync", hsync_s, 1'b0);
    chk("drop1_pix_x", pix_x_s, 10'h3FF);
    step();
    chk("drop2_frame_start", frame_start_s, 1'b1);
    step();
    chk("drop3_frame_start", frame_start_s, 1'b1);
    locked_s = 1'b1;
    for (int k = 0; k < 3; k++) step();
    chk("relock_c3_hsync", hsync_s, 1'b0);
    step();
    chk("relock_c4_hsync", hsync_s, 1'b1);
    chk("relock_c4_fs", frame_start_s, 1'b0);
    for (int k = 4; k < 152; k++) step();
    chk("relock_c152_fs", frame_start_s, 1'b0);
    step();
    chk("relock_c153_fs", frame_start_s, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
